// File: rtl/core_pkg.sv
// core_pkg: shared register-file constants and writeback request type.
//   REG_AW/XLEN   : unified register address width / data width
//   REG_ZERO      : x0, writes to it are discarded
//   FP_REG_BASE   : first FP register in the unified address space (32..63)
//   wb_req_t      : one writeback request (valid, addr, data)
package core_pkg;
  localparam int REG_AW      = 6;
  localparam int XLEN        = 32;
  localparam int REG_ZERO    = 0;
  localparam int FP_REG_BASE = 32;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] addr;
    logic [XLEN-1:0]   data;
  } wb_req_t;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: writeback requests in, register-file write port out.
//   req_valid/req_addr/req_data : per-source requests, packed, source i at [i*W +: W]
//   req_ready                   : per-source accept (transfer on valid&ready)
//   hold                        : downstream stall
//   wb_we/wb_addr/wb_data/wb_src: registered register-file write
// master: requesters + register file side; slave: the arbiter.
interface regfile_wb_arbiter_if #(
  parameter int N_SRC = 3,
  parameter int AW    = 6,
  parameter int DW    = 32
);
  localparam int SW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [N_SRC-1:0]    req_valid;
  logic [N_SRC*AW-1:0] req_addr;
  logic [N_SRC*DW-1:0] req_data;
  logic [N_SRC-1:0]    req_ready;
  logic                hold;
  logic                wb_we;
  logic [AW-1:0]       wb_addr;
  logic [DW-1:0]       wb_data;
  logic [SW-1:0]       wb_src;

  modport master (output req_valid, req_addr, req_data, hold,
                  input  req_ready, wb_we, wb_addr, wb_data, wb_src);
  modport slave  (input  req_valid, req_addr, req_data, hold,
                  output req_ready, wb_we, wb_addr, wb_data, wb_src);
endinterface

// File: rtl/regfile_wb_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick.
//   req : request vector
//   ptr : highest-priority index this cycle (must be < N)
//   gnt : one-hot grant, idx : winner index, any : some request present
module rr_arbiter #(
  parameter int N  = 3,
  parameter int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [SW-1:0] idx,
  output logic          any
);
  int          j;
  logic [SW-1:0] jj;

  // Scan ptr, ptr+1, ... wrapping at N; first hit wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    jj  = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      jj = SW'(j);
      if (!any && req[jj]) begin
        any     = 1'b1;
        gnt[jj] = 1'b1;
        idx     = jj;
      end
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin share of the register-file write port.
//   clk, rstn : clock, synchronous active-low reset
//   bus       : regfile_wb_arbiter_if.slave (requests in, wb_* write out)
// Optional (WB_ARB_PERF_EN): perf_grant_cnt (per-source grants, 32b each),
//   perf_conflict_cnt (cycles with >1 eligible source and no hold).
module regfile_wb_arbiter
  import core_pkg::*;
#(
  parameter int N_SRC = 3,
  parameter int AW    = REG_AW,
  parameter int DW    = XLEN
) (
  input  logic                   clk,
  input  logic                   rstn,
  regfile_wb_arbiter_if.slave    bus
`ifdef WB_ARB_PERF_EN
  ,
  output logic [N_SRC*32-1:0]    perf_grant_cnt,
  output logic [31:0]            perf_conflict_cnt
`endif
);
  localparam int SW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } req_t;

  req_t [N_SRC-1:0] req;
  logic [N_SRC-1:0] is_x0, elig, gnt;
  logic [SW-1:0]    rr_ptr, win;
  logic             any, grant;

  logic             we_q;
  logic [AW-1:0]    addr_q;
  logic [DW-1:0]    data_q;
  logic [SW-1:0]    src_q;

  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    assign req[i]   = '{valid: bus.req_valid[i],
                        addr:  bus.req_addr[i*AW +: AW],
                        data:  bus.req_data[i*DW +: DW]};
    assign is_x0[i] = req[i].valid && (req[i].addr == AW'(REG_ZERO));
    assign elig[i]  = req[i].valid && !is_x0[i];
  end

  rr_arbiter #(.N(N_SRC), .SW(SW)) u_rr (
    .req (elig),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (win),
    .any (any)
  );

  assign grant = rstn && !bus.hold && any;

  // x0 writes are swallowed immediately, regardless of hold/arbitration.
  assign bus.req_ready = {N_SRC{rstn}} & (is_x0 | ({N_SRC{grant}} & gnt));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      src_q  <= '0;
      rr_ptr <= '0;
    end else if (grant) begin
      we_q   <= 1'b1;
      addr_q <= req[win].addr;
      data_q <= req[win].data;
      src_q  <= win;
      rr_ptr <= (win == SW'(N_SRC-1)) ? '0 : win + 1'b1;
    end else begin
      we_q   <= 1'b0;
    end
  end

  assign bus.wb_we   = we_q;
  assign bus.wb_addr = addr_q;
  assign bus.wb_data = data_q;
  assign bus.wb_src  = src_q;

`ifdef WB_ARB_PERF_EN
  logic [N_SRC-1:0][31:0] grant_cnt;
  logic [31:0]            conflict_cnt;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      grant_cnt    <= '0;
      conflict_cnt <= '0;
    end else begin
      if (grant) grant_cnt[win] <= grant_cnt[win] + 32'd1;
      if (!bus.hold && ($countones(elig) > 1)) conflict_cnt <= conflict_cnt + 32'd1;
    end
  end

  assign perf_grant_cnt    = grant_cnt;
  assign perf_conflict_cnt = conflict_cnt;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed + random stimulus against a behavioural
// model of round-robin writeback arbitration. Build with WB_ARB_PERF_EN to
// also check the performance counters.
module tb_regfile_wb_arbiter;
  localparam int N  = 3;
  localparam int AW = 6;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.N_SRC(N), .AW(AW), .DW(DW)) bus ();

`ifdef WB_ARB_PERF_EN
  logic [N*32-1:0] perf_grant_cnt;
  logic [31:0]     perf_conflict_cnt;
`endif

  regfile_wb_arbiter #(.N_SRC(N), .AW(AW), .DW(DW)) dut (
    .clk               (clk),
    .rstn              (rstn),
    .bus               (bus)
`ifdef WB_ARB_PERF_EN
    ,
    .perf_grant_cnt    (perf_grant_cnt),
    .perf_conflict_cnt (perf_conflict_cnt)
`endif
  );

  int checks = 0;
  int passes = 0;

  // Reference model state
  int            m_ptr;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  int            m_src;
  int            m_win;
  int            m_nelig;
  logic [N-1:0]  m_ready;
  logic [31:0]   m_gcnt [N];
  logic [31:0]   m_conf;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
  endtask

  function automatic logic [AW-1:0] addr_of(input int i);
    logic [N*AW-1:0] v;
    v = bus.req_addr;
    return v[i*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] data_of(input int i);
    logic [N*DW-1:0] v;
    v = bus.req_data;
    return v[i*DW +: DW];
  endfunction

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_valid[i]          = v;
    bus.req_addr[i*AW +: AW]  = a;
    bus.req_data[i*DW +: DW]  = d;
  endtask

  task automatic clear_all();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, '0, '0);
  endtask

  // Decide this cycle's winner and expected ready from the current inputs.
  task automatic model_eval();
    m_win   = -1;
    m_nelig = 0;
    m_ready = '0;
    if (rstn) begin
      for (int i = 0; i < N; i++) begin
        if (bus.req_valid[i] && addr_of(i) == 0) m_ready[i] = 1'b1;
        if (bus.req_valid[i] && addr_of(i) != 0) m_nelig++;
      end
      if (!bus.hold) begin
        for (int k = 0; k < N; k++) begin
          int j;
          j = (m_ptr + k) % N;
          if (m_win < 0 && bus.req_valid[j] && addr_of(j) != 0) m_win = j;
        end
        if (m_win >= 0) m_ready[m_win] = 1'b1;
      end
    end
  endtask

  task automatic check_perf(input string tag);
`ifdef WB_ARB_PERF_EN
    for (int i = 0; i < N; i++) chk({tag, ".perf_grant"}, 64'(perf_grant_cnt[i*32 +: 32]), 64'(m_gcnt[i]));
    chk({tag, ".perf_conflict"}, 64'(perf_conflict_cnt), 64'(m_conf));
`else
    checks = checks + 0;
`endif
  endtask

  // One clock: check ready before the edge, advance model, check wb_* after.
  task automatic cycle(input string tag);
    #1;
    model_eval();
    chk({tag, ".ready"}, 64'(bus.req_ready), 64'(m_ready));
    @(posedge clk);
    if (!rstn) begin
      m_we = 0; m_addr = '0; m_data = '0; m_src = 0; m_ptr = 0; m_conf = '0;
      for (int i = 0; i < N; i++) m_gcnt[i] = '0;
    end else begin
      if (m_win >= 0) begin
        m_we = 1; m_addr = addr_of(m_win); m_data = data_of(m_win); m_src = m_win;
        m_ptr = (m_win + 1) % N;
        m_gcnt[m_win] = m_gcnt[m_win] + 32'd1;
      end else begin
        m_we = 0;
      end
      if (!bus.hold && m_nelig > 1) m_conf = m_conf + 32'd1;
    end
    #1;
    chk({tag, ".wb_we"},   64'(bus.wb_we),   64'(m_we));
    chk({tag, ".wb_addr"}, 64'(bus.wb_addr), 64'(m_addr));
    chk({tag, ".wb_data"}, 64'(bus.wb_data), 64'(m_data));
    chk({tag, ".wb_src"},  64'(bus.wb_src),  64'(m_src));
  endtask

  initial begin
    m_ptr = 0; m_we = 0; m_addr = '0; m_data = '0; m_src = 0; m_conf = '0;
    for (int i = 0; i < N; i++) m_gcnt[i] = '0;

    // Reset with requests present: nothing accepted, outputs zero.
    rstn = 1'b0;
    bus.hold = 1'b0;
    set_req(0, 1, 6'd3, 32'h1); set_req(1, 1, 6'd0, 32'h2); set_req(2, 1, 6'd9, 32'h3);
    cycle("rst0");
    cycle("rst1");
    check_perf("rst");
    rstn = 1'b1;

    // All three continuously valid -> 0,1,2,0,1,2 back to back.
    set_req(0, 1, 6'd1, 32'hA0); set_req(1, 1, 6'd2, 32'hA1); set_req(2, 1, 6'd33, 32'hA2);
    for (int k = 0; k < 6; k++) begin
      cycle("rr");
      chk("rr.seq_src", 64'(bus.wb_src), 64'(k % 3));
      chk("rr.seq_we", 64'(bus.wb_we), 64'd1);
    end
    clear_all();
    cycle("idle");

    // Single source 1 write.
    set_req(1, 1, 6'd5, 32'hDEADBEEF);
    cycle("single");
    clear_all();
    chk("single.addr", 64'(bus.wb_addr), 64'd5);
    chk("single.data", 64'(bus.wb_data), 64'hDEADBEEF);
    chk("single.src", 64'(bus.wb_src), 64'd1);
    cycle("single_after");
    chk("single.we_drop", 64'(bus.wb_we), 64'd0);

    // x0 request discarded alongside a real one.
    set_req(0, 1, 6'd0, 32'h55); set_req(2, 1, 6'd7, 32'h77);
    cycle("x0");
    clear_all();
    chk("x0.addr", 64'(bus.wb_addr), 64'd7);
    chk("x0.src", 64'(bus.wb_src), 64'd2);
    cycle("x0_after");

    // Hold for 4 cycles, then release.
    bus.hold = 1'b1;
    set_req(1, 1, 6'd12, 32'h1234);
    for (int k = 0; k < 4; k++) begin
      cycle("hold");
      chk("hold.we", 64'(bus.wb_we), 64'd0);
    end
    bus.hold = 1'b0;
    cycle("unhold");
    clear_all();
    chk("unhold.addr", 64'(bus.wb_addr), 64'd12);

    // Bring pointer back to 0 via a source-2 grant.
    set_req(2, 1, 6'd40, 32'h99);
    cycle("ptr_fix");
    clear_all();

    // Same destination from sources 0 and 1.
    set_req(0, 1, 6'd40, 32'h11); set_req(1, 1, 6'd40, 32'h22);
    cycle("same0");
    set_req(0, 0, 6'd0, 32'h0);
    chk("same.first", 64'(bus.wb_data), 64'h11);
    cycle("same1");
    clear_all();
    chk("same.second", 64'(bus.wb_data), 64'h22);
    cycle("same_after");

    // Reset asserted during a granted cycle.
    set_req(0, 1, 6'd4, 32'hC0); set_req(1, 1, 6'd36, 32'hC1); set_req(2, 1, 6'd8, 32'hC2);
    cycle("pre_rst");
    rstn = 1'b0;
    cycle("mid_rst");
    chk("mid_rst.we", 64'(bus.wb_we), 64'd0);
    check_perf("mid_rst");
    rstn = 1'b1;

    // Random traffic. Unaccepted eligible requests stay stable.
    for (int c = 0; c < 400; c++) begin
      logic [N-1:0] acc;
      cycle("rand");
      acc = m_ready;
      for (int i = 0; i < N; i++) begin
        if (!bus.req_valid[i] || acc[i]) begin
          if ($urandom_range(0, 2) != 0) begin
            logic [AW-1:0] a;
            a = ($urandom_range(0, 7) == 0) ? 6'd0 : AW'($urandom_range(1, 63));
            set_req(i, 1, a, $urandom);
          end else begin
            set_req(i, 0, '0, '0);
          end
        end
      end
      bus.hold = ($urandom_range(0, 4) == 0);
      rstn     = ($urandom_range(0, 99) != 0);
    end
    rstn = 1'b1;
    bus.hold = 1'b0;
    cycle("rand_end");
    check_perf("final");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (we/waddr/wdata, 6-bit unified address space: 0-31 integer, 32-63 FP) between N_SRC writeback requesters (ALU, load unit, FPU, ...).
- Round-robin arbitration over valid/ready handshakes, one write per cycle, registered output.
- Sits between the execute/memory units and the register file.

Parameters:
- N_SRC, 3, number of writeback requesters (2..8).
- AW, 6, register address width.
- DW, 32, data width.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- req_valid  in  N_SRC  per-source write request
- req_addr  in  N_SRC*AW  per-source destination register, packed, source i at [i*AW +: AW]
- req_data  in  N_SRC*DW  per-source write data, packed
- req_ready  out  N_SRC  per-source accept; transfer when valid&ready
- hold  in  1  downstream stall; no grants while high
- wb_we  out  1  register-file write enable
- wb_addr  out  AW  register-file write address
- wb_data  out  DW  register-file write data
- wb_src  out  $clog2(N_SRC)  index of the source that produced the current write

Behaviour:
- Reset (rstn=0 at posedge): wb_we=0, wb_addr=0, wb_data=0, wb_src=0, rr_ptr=0. req_ready is combinational and is 0 while rstn=0.
- req_ready is combinational from req_valid, req_addr, rr_ptr, hold, rstn. No ready-to-valid dependency: valid must not depend on ready.
- Address-0 requests (x0) are discarded: req_ready=1 whenever rstn=1, independent of hold and arbitration. They never produce wb_we and never advance rr_ptr.
- Eligible source: valid=1 and addr!=0.
- Grant when hold=0 and at least one source is eligible.
  - Winner is the first eligible index scanning rr_ptr, rr_ptr+1, ... modulo N_SRC.
  - Exactly one eligible source gets ready=1. All other eligible sources get ready=0 and must hold their request stable.
- Latency 1: at the posedge of a grant, wb_we<=1, wb_addr/wb_data<=winner's request, wb_src<=winner, rr_ptr<=(winner+1) mod N_SRC. Wrap-around: from N_SRC-1 the pointer goes to 0.
- Cycles with no grant (hold=1 or nothing eligible): wb_we<=0. wb_addr, wb_data and wb_src keep their values. rr_ptr is unchanged.
- hold=1: no eligible source is accepted. An in-flight registered write (already on wb_*) still completes that cycle.
- Same destination from two sources in one cycle: both are written in arbitration order on successive cycles, so the last granted value persists. Ordering between sources is the requesters' responsibility.
- Fairness: a continuously eligible source is granted within N_SRC grant cycles.
- Reset mid-operation: a pending registered write is dropped (wb_we=0 next cycle). All requests are refused during reset.
- State: rr_ptr (round-robin pointer) plus the output register. No further FSM.

Optional Feature:
- Macro WB_ARB_PERF_EN.
- When defined:
  - Adds outputs perf_grant_cnt (N_SRC*32, per-source grant counters) and perf_conflict_cnt (32, cycles where more than one source was eligible and hold=0).
  - Counters wrap modulo 2^32 and are cleared by reset.
- When undefined: these ports and registers are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package core_pkg:
  - REG_AW=6, XLEN=32.
  - Constants REG_ZERO=0 and FP_REG_BASE=32.
  - typedef wb_req_t {logic valid; logic [5:0] addr; logic [31:0] data}.
- One natural sub-module: rr_arbiter. It takes a request vector and pointer and returns a one-hot grant plus the winner index. It is purely combinational and reusable by a later memory-port arbiter.

Test Plan:
- Single source 1 writes addr 5, data 0xDEADBEEF, hold=0 → req_ready[1]=1 same cycle; next cycle wb_we=1, wb_addr=5, wb_data=0xDEADBEEF, wb_src=1; the following cycle wb_we=0.
- All 3 sources continuously valid (addrs 1, 2, 33) starting with rr_ptr=0 → grants 0,1,2,0,1,2 on consecutive cycles, wb_we=1 every cycle, and no source waits more than 3 grants.
- Source 0 addr 0 and source 2 addr 7 in the same cycle → both ready=1; one write (addr 7, wb_src=2); rr_ptr=0.
- hold=1 for 4 cycles with source 1 valid → req_ready[1]=0 throughout and wb_we=0. After hold drops: ready=1 the same cycle and the write appears one cycle later.
- Sources 0 and 1 both target addr 40 (data 0x11, then 0x22) with rr_ptr=0 → write 0x11 then 0x22 on successive cycles.
- rstn=0 asserted during a granted cycle → next cycle wb_we=0, all outputs 0, rr_ptr=0, and all req_ready=0 while in reset. With WB_ARB_PERF_EN defined, all counters read 0 after reset.
